// File: rtl/ch_readout_collector_pkg.sv
// Purpose: shared register-select codes, FSM state codes and widths for the readout collector.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package ch_readout_collector_pkg;

    localparam int NUM_REGS = 6;
    localparam int CNT_W    = 10;

    // Register select codes driven onto SELECT_REG; order is the readout order.
    typedef enum logic [2:0] {
        CA       = 3'd0,
        CB       = 3'd1,
        CC       = 3'd2,
        CD       = 3'd3,
        CE       = 3'd4,
        TRIG_CNT = 3'd5
    } rsel_t;

    // Collector FSM state codes.
    typedef logic [2:0] rd_state_t;
    localparam rd_state_t IDLE  = 3'd0;
    localparam rd_state_t LOAD  = 3'd1;
    localparam rd_state_t WAIT  = 3'd2;
    localparam rd_state_t SHIFT = 3'd3;
    localparam rd_state_t PUSH  = 3'd4;
    localparam rd_state_t DONE  = 3'd5;

    // True for the last register of a channel (trigger counter).
    function automatic logic is_last_reg(input rsel_t r);
        return int'(r) == NUM_REGS - 1;
    endfunction

    // Next register in readout order; wraps to CA after the trigger counter.
    function automatic rsel_t next_rsel(input rsel_t r);
        return is_last_reg(r) ? CA : rsel_t'(r + 3'd1);
    endfunction

endpackage

// File: rtl/ch_readout_deser.sv
// Purpose: MSB-first serial-to-parallel shifter with bit counter for one readout word.
// Latency: WORD_W shift cycles; last_bit is combinational on the final shift cycle.
// Backpressure: none, shifts whenever shift_en is high; the owner holds shift_en low to pause.
module ch_readout_deser #(
    parameter int WORD_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic [WORD_W-1:0] shift_nxt,
    output logic              last_bit
);

    localparam int               BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;

    // Value the shift register takes this cycle: the first bit ends up in the MSB.
    assign shift_nxt = (shreg << 1) | WORD_W'(ser_in);
    assign last_bit  = shift_en && (bit_cnt == LAST_IDX);

    // Shift one bit per enabled cycle; a new load clears any stale partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= shift_nxt;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ch_readout_collector.sv
// Purpose: drains the enabled channels' timestamp registers (CA..CE, trigger count) into tagged words.
// Latency: per word 1 LOAD + (LAT-1) WAIT + WORD_W SHIFT + 1 PUSH cycles; done 2 cycles after start on an empty mask.
// Backpressure: holds in PUSH with word_data/tags stable until word_ready; no new load is issued meanwhile.
module ch_readout_collector
    import ch_readout_collector_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WORD_W = CNT_W,
    parameter int LAT    = 1
) (
    input  logic                      SPI_CLK,
    input  logic                      RSTB,
    input  logic                      start_readout,
    input  logic [NUM_CH-1:0]         ch_mask,
    output logic                      INST_READOUT,
    output logic [2:0]                SELECT_REG,
    output logic [$clog2(NUM_CH)-1:0] CH_SEL,
    input  logic                      CNT_SER,
    output logic [WORD_W-1:0]         word_data,
    output logic [$clog2(NUM_CH)-1:0] word_ch,
    output logic [2:0]                word_reg,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int         CH_W      = $clog2(NUM_CH);
    // With LAT=1 the first bit is already valid in the cycle after LOAD.
    localparam rd_state_t  POST_LOAD = (LAT > 1) ? WAIT : SHIFT;
    // The wait counter counts down to zero, so it starts at LAT-2 for LAT-1 wait cycles.
    localparam logic [1:0] WAIT_INIT = 2'((LAT > 1) ? LAT - 2 : 0);

    rd_state_t         state;
    logic              start_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CH_W-1:0]   ch_idx;
    rsel_t             reg_idx;
    logic [1:0]        wait_cnt;

    logic              start_acc;
    logic              first_found;
    logic [CH_W-1:0]   first_ch;
    logic              next_found;
    logic [CH_W-1:0]   next_ch;

    logic              deser_clr;
    logic              shift_en;
    logic              last_bit;
    logic [WORD_W-1:0] shift_nxt;

    // A start is taken only from a quiet IDLE; anything arriving while busy is dropped.
    assign start_acc = start_readout && (state == IDLE) && !start_q;

    // Register the start pulse and freeze the channel mask for the whole readout.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            start_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            start_q <= start_acc;
            if (start_acc) begin
                mask_q <= ch_mask;
            end
        end
    end

    // Find the lowest enabled channel and the lowest enabled channel above the current one.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_idx))) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    // Readout sequencer: channel scan, register walk, latency wait and output handshake.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= IDLE;
            ch_idx    <= '0;
            reg_idx   <= CA;
            wait_cnt  <= '0;
            word_data <= '0;
            word_ch   <= '0;
            word_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_q) begin
                        if (first_found) begin
                            ch_idx  <= first_ch;
                            reg_idx <= CA;
                            state   <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= POST_LOAD;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        word_data <= shift_nxt;
                        word_ch   <= ch_idx;
                        word_reg  <= reg_idx;
                        state     <= PUSH;
                    end
                end
                PUSH: begin
                    if (word_ready) begin
                        if (!is_last_reg(reg_idx)) begin
                            reg_idx <= next_rsel(reg_idx);
                            state   <= LOAD;
                        end else if (next_found) begin
                            ch_idx  <= next_ch;
                            reg_idx <= CA;
                            state   <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign deser_clr = (state == LOAD);
    assign shift_en  = (state == SHIFT);

    ch_readout_deser #(
        .WORD_W(WORD_W)
    ) u_deser (
        .clk      (SPI_CLK),
        .rst_n    (RSTB),
        .clr      (deser_clr),
        .shift_en (shift_en),
        .ser_in   (CNT_SER),
        .shift_nxt(shift_nxt),
        .last_bit (last_bit)
    );

    // Channel-side controls follow the held indices; the load strobe is LOAD only.
    assign INST_READOUT = (state == LOAD);
    assign SELECT_REG   = reg_idx;
    assign CH_SEL       = ch_idx;

    // Transmit-side status.
    assign word_valid = (state == PUSH);
    assign busy       = start_q || (state inside {LOAD, WAIT, SHIFT, PUSH});
    assign done       = (state == DONE);

endmodule

// File: tb/tb_ch_readout_collector.sv
// Bench for ch_readout_collector: two instances (LAT=1 and LAT=3) fed by a
// behavioural channel model; every accepted word is checked against a list
// built directly from the enabled channels and their register contents.
module tb_ch_readout_collector;

    logic       spi_clk = 1'b0;
    logic       rstb;
    logic       start_readout [2];
    logic [7:0] ch_mask       [2];
    logic       inst_readout  [2];
    logic [2:0] select_reg    [2];
    logic [2:0] ch_sel        [2];
    logic       cnt_ser       [2];
    logic [9:0] word_data     [2];
    logic [2:0] word_ch       [2];
    logic [2:0] word_reg      [2];
    logic       word_valid    [2];
    logic       word_ready    [2];
    logic       busy          [2];
    logic       done          [2];

    int checks   = 0;
    int failures = 0;

    // Channel register contents: CA..CE per channel plus a 3-bit trigger count.
    logic [9:0] regs [8][5];
    logic [2:0] trig [8];

    always #5 spi_clk = ~spi_clk;

    ch_readout_collector #(.NUM_CH(8), .WORD_W(10), .LAT(1)) u_dut0 (
        .SPI_CLK(spi_clk), .RSTB(rstb), .start_readout(start_readout[0]), .ch_mask(ch_mask[0]),
        .INST_READOUT(inst_readout[0]), .SELECT_REG(select_reg[0]), .CH_SEL(ch_sel[0]),
        .CNT_SER(cnt_ser[0]), .word_data(word_data[0]), .word_ch(word_ch[0]), .word_reg(word_reg[0]),
        .word_valid(word_valid[0]), .word_ready(word_ready[0]), .busy(busy[0]), .done(done[0])
    );

    ch_readout_collector #(.NUM_CH(8), .WORD_W(10), .LAT(3)) u_dut1 (
        .SPI_CLK(spi_clk), .RSTB(rstb), .start_readout(start_readout[1]), .ch_mask(ch_mask[1]),
        .INST_READOUT(inst_readout[1]), .SELECT_REG(select_reg[1]), .CH_SEL(ch_sel[1]),
        .CNT_SER(cnt_ser[1]), .word_data(word_data[1]), .word_ch(word_ch[1]), .word_reg(word_reg[1]),
        .word_valid(word_valid[1]), .word_ready(word_ready[1]), .busy(busy[1]), .done(done[1])
    );

    // What a channel shifts out for a register: the trigger count is zero-padded to 10 bits.
    function automatic logic [9:0] exp_val(input logic [2:0] ch, input logic [2:0] r);
        if (r == 3'd5) return {7'd0, trig[ch]};
        if (r < 3'd5)  return regs[ch][r];
        return 10'h3AA;
    endfunction

    function automatic logic [31:0] outs(input int d);
        return 32'({inst_readout[d], select_reg[d], ch_sel[d], word_data[d], word_ch[d],
                    word_reg[d], word_valid[d], busy[d], done[d]});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 5; r++) regs[c][r] = 10'($urandom);
            trig[c] = 3'($urandom);
        end
    endtask

    // Channel model: the load strobe latches the selected register; bit k (MSB first)
    // is on CNT_SER during the cycle LAT+k after LOAD; other cycles carry random junk.
    int         ser_ctr  [2];
    logic [9:0] ser_word [2];
    logic       ser_act  [2];
    always @(negedge spi_clk) begin
        for (int d = 0; d < 2; d++) begin
            int lat_d;
            int k;
            lat_d = (d == 0) ? 1 : 3;
            if (!rstb) begin
                ser_act[d] = 1'b0;
                ser_ctr[d] = 0;
                cnt_ser[d] = 1'b0;
            end else if (inst_readout[d]) begin
                ser_act[d]  = 1'b1;
                ser_ctr[d]  = 0;
                ser_word[d] = exp_val(ch_sel[d], select_reg[d]);
                cnt_ser[d]  = 1'($urandom);
            end else begin
                ser_ctr[d] = ser_ctr[d] + 1;
                k = ser_ctr[d] - lat_d;
                if (ser_act[d] && k >= 0 && k < 10) cnt_ser[d] = ser_word[d][9-k];
                else                                cnt_ser[d] = 1'($urandom);
            end
        end
    end

    // One full readout on instance d; checks words, order, strobes, timing and handshake rules.
    task automatic run_seq(input int d, input logic [7:0] mask, input int stall,
                           input bit rnd_ready, input bit second_start, input string name);
        logic [15:0] exp_list[$];
        logic [15:0] expq[$];
        logic [15:0] cur_word, prev_word;
        logic        prev_valid, prev_ready;
        logic [2:0]  cur_ch;
        int cyc, first_load, last_load, last_hs, done_cyc, n_loads, n_words, total;
        int bad_sel, bad_load, bad_busy, bad_hold, bad_lat, stall_left, lat_exp;

        for (int c = 0; c < 8; c++)
            if (mask[c])
                for (int r = 0; r < 6; r++)
                    exp_list.push_back({3'(c), 3'(r), exp_val(3'(c), 3'(r))});
        expq = exp_list;
        total = exp_list.size();
        lat_exp = (d == 0) ? 11 : 13;
        first_load = -1; last_load = -1; last_hs = -1; done_cyc = -1;
        n_loads = 0; n_words = 0; bad_sel = 0; bad_load = 0; bad_busy = 0; bad_hold = 0; bad_lat = 0;
        stall_left = stall; prev_valid = 1'b0; prev_ready = 1'b1; prev_word = '0; cur_ch = '0;

        @(negedge spi_clk);
        start_readout[d] = 1'b1;
        ch_mask[d] = mask;
        word_ready[d] = 1'b1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 3000) begin
            if (cyc == 1) begin
                start_readout[d] = 1'b0;
                ch_mask[d] = 8'($urandom);
            end
            if (second_start && cyc == 30) start_readout[d] = 1'b1;
            if (second_start && cyc == 31) start_readout[d] = 1'b0;

            if (busy[d] !== (cyc >= 1 && done[d] !== 1'b1)) bad_busy++;
            if (prev_valid && !prev_ready) begin
                cur_word = {word_ch[d], word_reg[d], word_data[d]};
                if (word_valid[d] !== 1'b1 || cur_word !== prev_word || inst_readout[d] !== 1'b0) bad_hold++;
            end
            if (inst_readout[d] === 1'b1) begin
                if (first_load < 0) first_load = cyc;
                last_load = cyc;
                if (mask[ch_sel[d]] !== 1'b1) bad_sel++;
                if (n_loads >= total) bad_load++;
                else if ({ch_sel[d], select_reg[d]} !== exp_list[n_loads][15:10]) bad_load++;
                n_loads++;
                cur_ch = ch_sel[d];
            end
            if (first_load >= 0 && busy[d] === 1'b1 && ch_sel[d] !== cur_ch) bad_sel++;
            if (word_valid[d] === 1'b1 && !prev_valid && (cyc - last_load) != lat_exp) bad_lat++;

            if (word_valid[d] === 1'b1 && stall_left > 0) begin
                word_ready[d] = 1'b0;
                stall_left--;
            end else if (rnd_ready) begin
                word_ready[d] = ($urandom_range(0, 2) != 0);
            end else begin
                word_ready[d] = 1'b1;
            end

            cur_word = {word_ch[d], word_reg[d], word_data[d]};
            if (word_valid[d] === 1'b1 && word_ready[d]) begin
                n_words++;
                last_hs = cyc;
                if (expq.size() > 0) check({name, "_word"}, 32'(cur_word), 32'(expq.pop_front()));
            end
            if (done[d] === 1'b1) done_cyc = cyc;
            prev_valid = (word_valid[d] === 1'b1);
            prev_ready = word_ready[d];
            prev_word  = cur_word;
            if (done_cyc < 0) begin
                @(negedge spi_clk);
                cyc++;
            end
        end
        word_ready[d] = 1'b1;

        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, "_nwords"}, n_words, total);
        check({name, "_nloads"}, n_loads, total);
        check({name, "_load_order"}, bad_load, 0);
        check({name, "_ch_sel"}, bad_sel, 0);
        check({name, "_busy"}, bad_busy, 0);
        check({name, "_hold"}, bad_hold, 0);
        check({name, "_valid_lat"}, bad_lat, 0);
        if (total == 0) begin
            check({name, "_empty_done_cyc"}, done_cyc, 2);
        end else begin
            check({name, "_first_load"}, first_load, 2);
            check({name, "_done_after_hs"}, done_cyc, last_hs + 1);
            if (!rnd_ready)
                check({name, "_done_time"}, done_cyc - first_load, total * (lat_exp + 1) + stall);
        end
        @(negedge spi_clk);
        check({name, "_done_pulse"}, 32'({done[d], busy[d]}), 32'd0);
    endtask

    initial begin
        logic [7:0] m;
        int n;

        rstb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_readout[d] = 1'b0;
            ch_mask[d] = '0;
            word_ready[d] = 1'b1;
        end
        fill_mem();
        repeat (3) @(negedge spi_clk);
        check("reset_outs0", outs(0), 32'd0);
        check("reset_outs1", outs(1), 32'd0);
        rstb = 1'b1;
        @(negedge spi_clk);
        check("idle_outs0", outs(0), 32'd0);

        // Single channel with the directed register contents.
        regs[0][0] = 10'h2A5; regs[0][1] = 10'h155; regs[0][2] = 10'h000;
        regs[0][3] = 10'h3FF; regs[0][4] = 10'h001; trig[0] = 3'd5;
        run_seq(0, 8'b0000_0001, 0, 1'b0, 1'b0, "single");
        run_seq(0, 8'b1000_0100, 0, 1'b0, 1'b0, "sparse");
        run_seq(0, 8'b0000_1000, 20, 1'b0, 1'b0, "stall");
        run_seq(0, 8'b0000_0000, 0, 1'b0, 1'b0, "empty");
        run_seq(1, 8'b0000_0001, 0, 1'b0, 1'b0, "lat3");

        // Reset during SHIFT of ch 0 reg 2, then a clean restart.
        @(negedge spi_clk);
        start_readout[0] = 1'b1;
        ch_mask[0] = 8'h01;
        @(negedge spi_clk);
        start_readout[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge spi_clk);
            if (inst_readout[0] === 1'b1) n++;
        end
        check("rst_reach_reg2", n, 3);
        check("rst_selreg", 32'(select_reg[0]), 32'd2);
        repeat (4) @(negedge spi_clk);
        rstb = 1'b0;
        #1;
        check("rst_outs_now", outs(0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge spi_clk);
            check("rst_outs_hold", outs(0), 32'd0);
        end
        rstb = 1'b1;
        @(negedge spi_clk);
        run_seq(0, 8'b0000_0001, 0, 1'b0, 1'b1, "restart");

        // Random masks, contents and ready patterns on both instances.
        for (int it = 0; it < 4; it++) begin
            fill_mem();
            m = 8'($urandom);
            run_seq(it % 2, m, 0, 1'b1, 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ch_readout_collector.md
Name: ch_readout_collector

Overview:
- SPI-clock-domain readout master that drains the per-channel timestamp shift registers after sampling stops.
- For each enabled channel it walks select codes 0..5, pulses INST_READOUT, steers the readout mux via CH_SEL and deserialises 10 bits of CNT_SER per register.
- Assembled words, tagged with channel and register, go to the SPI transmit buffer over a valid/ready handshake.

Parameters:
- NUM_CH, 8, number of channels behind the readout mux.
- WORD_W, 10, bits per serial word (counter width).
- LAT, 1, SPI_CLK cycles from the end of the LOAD cycle to the first valid CNT_SER bit; range 1..4.

Ports:
- SPI_CLK  in  1  40 MHz SPI clock; all state is on its rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- start_readout  in  1  one-cycle pulse from the SPI command decoder.
- ch_mask  in  NUM_CH  1 = channel enabled; sampled at start_readout.
- INST_READOUT  out  1  load strobe to the channels, high during LOAD only.
- SELECT_REG  out  3  register select: 0=CA, 1=CB, 2=CC, 3=CD, 4=CE, 5=trigger_cnt.
- CH_SEL  out  clog2(NUM_CH)  readout mux select.
- CNT_SER  in  1  serial data from the mux, MSB first.
- word_data  out  WORD_W  deserialised word.
- word_ch  out  clog2(NUM_CH)  channel tag.
- word_reg  out  3  register tag.
- word_valid  out  1  word available.
- word_ready  in  1  transmit buffer accepts.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values:
  - all outputs 0.
  - state IDLE; channel and register indices 0; shift register 0.
- IDLE
  - start_readout=1 latches ch_mask and selects the lowest enabled channel, with reg index 0. Next state LOAD.
  - If the latched mask is all zero, next state is DONE instead; no words are produced.
- LOAD (1 cycle)
  - INST_READOUT=1; SELECT_REG and CH_SEL show the current indices.
  - SELECT_REG and CH_SEL hold their values through WAIT, SHIFT and PUSH.
  - Next state: WAIT if LAT>1, else SHIFT.
- WAIT
  - Lasts LAT-1 cycles, counted down by a counter. Next state SHIFT.
- SHIFT (WORD_W cycles)
  - Each cycle the shift register shifts left and captures CNT_SER into bit 0, so the first bit lands in the MSB.
  - A bit counter runs from 0 to WORD_W-1.
  - On the last bit, the word is copied into word_data and tagged with word_ch and word_reg. Next state PUSH.
- PUSH
  - word_valid=1. word_data and the tags stay stable until word_ready=1.
  - On the handshake:
    - If reg<5: reg+1, then LOAD.
    - Else: reg=0 and advance to the next enabled channel in ascending order, then LOAD.
    - If no enabled channel remains: DONE.
- DONE (1 cycle)
  - done=1, busy=0, then IDLE.
- Timing:
  - With LAT=1 and word_ready held high, each word costs 12 cycles: LOAD 1 + SHIFT 10 + PUSH 1.
  - word_valid rises 11 cycles after INST_READOUT.
- trigger_cnt (reg 5):
  - The channel sends a 3-bit value zero-padded to 10 bits.
  - The collector forwards all 10 bits unchanged; no width conversion.
- start_readout while busy is ignored. ch_mask changes while busy have no effect.
- word_ready is ignored outside PUSH. word_valid never drops without a handshake.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - A partial word is discarded.
  - The channels must be reset together via RSTB.
- Channel index never wraps: after the highest enabled channel, the collector goes to DONE.

Decomposition:
- Package types_pkg gains:
  - rsel_t: 3-bit enum CA..TRIG_CNT = 0..5.
  - rd_state_t: IDLE, LOAD, WAIT, SHIFT, PUSH, DONE.
  - Constants NUM_REGS=6 and CNT_W=10.
- Sub-module ch_readout_deser holds the WORD_W shift register, the bit counter and the last-bit flag.
- The FSM, channel scan and handshake stay in the top level.

Test Plan:
- Single channel: ch_mask=8'b0000_0001; channel model holds CA=10'h2A5, CB=10'h155, CC=0, CD=10'h3FF, CE=10'h001, trigger_cnt=3'd5. Pulse start with ready=1.
  - Expect 6 words (reg 0..5, ch 0) with values 2A5, 155, 000, 3FF, 001, 005.
  - done 72 cycles after the first LOAD.
- Sparse mask: ch_mask=8'b1000_0100.
  - Expect 12 words, ch 2 then ch 7, regs 0..5 each.
  - CH_SEL never takes values other than 2 or 7.
- Backpressure: hold word_ready low for 20 cycles at the first PUSH.
  - word_valid and word_data stay stable, no INST_READOUT pulse, no words lost or duplicated.
- Empty mask: ch_mask=0.
  - done pulses 2 cycles after start; no INST_READOUT; word_valid stays 0.
- LAT=3: channel model delays its first bit by 2 extra cycles.
  - Words match, and the cycles between INST_READOUT and word_valid equal 13.
- Reset and restart: assert RSTB low during SHIFT of ch 0 reg 2, then pulse start again.
  - All outputs 0 during reset.
  - The restart produces a clean full sequence beginning at reg 0; the second start while busy is ignored.
